// File: rtl/systolic_driver.sv
// -----------------------------------------------------------------------------
// systolic_driver
// Front/back end for a weight-stationary systolic array.
//  - Collects a full weight matrix into a shadow buffer, then bursts it into the
//    array with set_w high for exactly `size` consecutive cycles, followed by a
//    low cycle so the array's internal row counter returns to zero.
//  - Skews accepted activation vectors (row r enters r cycles after row 0) and
//    deskews the array's column outputs into one aligned result vector.
//  - One activation vector per cycle via valid/ready; results have no backpressure.
//
// Ports
//  clk, rst           clock, asynchronous active-high reset
//  w_valid/w_ready    weight row handshake, w_row slot c -> column c
//  x_valid/x_ready    activation handshake, x_in slot r -> array row r
//  y_valid/y_out      one-cycle result pulse, y_out slot c = column c
//  data_stream        skewed activations to the array
//  w_stream, set_w    weight-load bus and strobe to the array
//  y_stream           combinational per-column results from the array
// Slots are MSB-first: slot 0 occupies the top data_size bits.
// -----------------------------------------------------------------------------
module systolic_driver #(
    parameter int unsigned data_size = 16,
    parameter int unsigned size      = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_valid,
    output logic                        w_ready,
    input  logic [data_size*size-1:0]   w_row,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic [data_size*size-1:0]   x_in,
    output logic                        y_valid,
    output logic [data_size*size-1:0]   y_out,
    output logic [data_size*size-1:0]   data_stream,
    output logic [data_size*size-1:0]   w_stream,
    output logic                        set_w,
    input  logic [data_size*size-1:0]   y_stream
);

    localparam int unsigned VW     = data_size * size;
    localparam int unsigned VDEPTH = 2 * size + 2;
    localparam int unsigned CW     = (size > 1) ? $clog2(size) : 1;

    typedef enum logic [2:0] {
        RUN,
        DRAIN,
        W_COLLECT,
        W_BURST,
        W_GAP
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              w_loaded, w_loaded_next;
    logic              shadow_we;
    logic              accept;

    logic [VW-1:0]        shadow [size];
    logic [data_size-1:0] x_stage [size];
    logic [VDEPTH-1:0]    vpipe;
    logic [VW-1:0]        deskew_out;

    // Next-state, handshake and shadow-write decode
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        w_loaded_next = w_loaded;
        w_ready       = 1'b0;
        x_ready       = 1'b0;
        shadow_we     = 1'b0;

        case (state)
            RUN: begin
                // A pending weight request blocks new activations this cycle
                x_ready = w_loaded && !w_valid;
                if (w_valid) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // In-flight vectors finish with the old weights first
                if (vpipe == '0) begin
                    state_next = W_COLLECT;
                    cnt_next   = '0;
                end
            end
            W_COLLECT: begin
                w_ready = 1'b1;
                if (w_valid) begin
                    shadow_we = 1'b1;
                    if (cnt == CW'(size - 1)) begin
                        state_next = W_BURST;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end
            end
            W_BURST: begin
                if (cnt == CW'(size - 1)) begin
                    state_next = W_GAP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            W_GAP: begin
                w_loaded_next = 1'b1;
                state_next    = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        accept = x_valid && x_ready;
    end

    // State register; set_w/w_stream are registered from the next state so they
    // are high exactly while the FSM sits in W_BURST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= '0;
            w_loaded <= 1'b0;
            set_w    <= 1'b0;
            w_stream <= '0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            w_loaded <= w_loaded_next;
            set_w    <= (state_next == W_BURST);
            w_stream <= (state_next == W_BURST) ? shadow[cnt_next] : '0;
        end
    end

    // Shadow weight buffer, row k stored in arrival order
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < size; k++) begin
                shadow[k] <= '0;
            end
        end else if (shadow_we) begin
            shadow[cnt] <= w_row;
        end
    end

    // Input stage, accept-flag pipe and aligned result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < size; r++) begin
                x_stage[r] <= '0;
            end
            vpipe   <= '0;
            y_valid <= 1'b0;
            y_out   <= '0;
        end else begin
            // Bubbles inject zeros so idle cycles contribute nothing
            for (int unsigned r = 0; r < size; r++) begin
                x_stage[r] <= accept ? x_in[(size-1-r)*data_size +: data_size] : '0;
            end
            vpipe   <= {vpipe[VDEPTH-2:0], accept};
            y_valid <= vpipe[VDEPTH-1];
            y_out   <= vpipe[VDEPTH-1] ? deskew_out : '0;
        end
    end

    // Skew: lane r is an (r+1)-deep chain behind the shared input stage
    for (genvar r = 0; r < size; r++) begin : g_lane
        logic [data_size-1:0] stage [r+1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k <= r; k++) begin
                    stage[k] <= '0;
                end
            end else begin
                stage[0] <= x_stage[r];
                for (int k = 1; k <= r; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
        end

        assign data_stream[(size-1-r)*data_size +: data_size] = stage[r];
    end

    // Deskew: column c emerges c cycles after column 0, so it waits size-c stages
    for (genvar c = 0; c < size; c++) begin : g_deskew
        localparam int unsigned DEPTH = size - c;
        logic [data_size-1:0] stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage[k] <= '0;
                end
            end else begin
                stage[0] <= y_stream[(size-1-c)*data_size +: data_size];
                for (int k = 1; k < DEPTH; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
        end

        assign deskew_out[(size-1-c)*data_size +: data_size] = stage[DEPTH-1];
    end

endmodule

// File: tb/tb_systolic_driver.sv
// -----------------------------------------------------------------------------
// tb_systolic_driver
// Drives systolic_driver against a behavioural weight-stationary array model.
// Expected results go into a scoreboard when a vector is accepted and are
// popped when y_valid pulses; latency from the accept edge must be 2*size+2.
// -----------------------------------------------------------------------------
module tb_systolic_driver;

    localparam int S  = 3;
    localparam int D  = 16;
    localparam int VW = D * S;
    localparam int LAT = 2 * S + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_valid = 1'b0;
    logic          x_valid = 1'b0;
    logic [VW-1:0] w_row = '0;
    logic [VW-1:0] x_in = '0;
    logic          w_ready, x_ready, y_valid, set_w;
    logic [VW-1:0] y_out, data_stream, w_stream, y_stream;

    always #5 clk = ~clk;

    systolic_driver #(.data_size(D), .size(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_row       (w_row),
        .x_valid     (x_valid),
        .x_ready     (x_ready),
        .x_in        (x_in),
        .y_valid     (y_valid),
        .y_out       (y_out),
        .data_stream (data_stream),
        .w_stream    (w_stream),
        .set_w       (set_w),
        .y_stream    (y_stream)
    );

    function automatic logic [D-1:0] slot(input logic [VW-1:0] v, input int i);
        return v[(S-1-i)*D +: D];
    endfunction

    function automatic logic [VW-1:0] pack3(input int a, input int b, input int c);
        return {D'(a), D'(b), D'(c)};
    endfunction

    // Reference: y[c] = sum_r W[r][c] * x[r]
    function automatic logic [VW-1:0] matvec(input logic [VW-1:0] w [S], input logic [VW-1:0] x);
        logic [VW-1:0] res;
        logic [D-1:0]  acc;
        res = '0;
        for (int c = 0; c < S; c++) begin
            acc = '0;
            for (int r = 0; r < S; r++) acc = acc + D'(slot(w[r], c) * slot(x, r));
            res[(S-1-c)*D +: D] = acc;
        end
        return res;
    endfunction

    // ---------------- behavioural array (no reset) ----------------
    logic [VW-1:0] arr_w [S]       = '{default: '0};
    logic [VW-1:0] hist  [2*S-1]   = '{default: '0};
    int            arr_cnt         = 0;

    always @(posedge clk) begin
        if (set_w) begin
            if (arr_cnt < S) arr_w[arr_cnt] <= w_stream;
            arr_cnt <= arr_cnt + 1;
        end else begin
            arr_cnt <= 0;
        end
        hist[0] <= data_stream;
        for (int k = 1; k < 2*S-1; k++) hist[k] <= hist[k-1];
    end

    // hist[k] holds data_stream of the cycle k+1 before the current one; x[r]
    // of a vector reaches column c's output S+c-r-1 cycles after entering row r
    function automatic logic [VW-1:0] array_out(input logic [VW-1:0] w [S], input logic [VW-1:0] h [2*S-1]);
        logic [VW-1:0] res;
        logic [D-1:0]  acc;
        res = '0;
        for (int c = 0; c < S; c++) begin
            acc = '0;
            for (int r = 0; r < S; r++) acc = acc + D'(slot(w[r], c) * slot(h[S+c-r-1], r));
            res[(S-1-c)*D +: D] = acc;
        end
        return res;
    endfunction

    always_comb y_stream = array_out(arr_w, hist);

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic [VW-1:0] y;
        int            edge_idx;
    } exp_t;

    typedef struct {
        logic [VW-1:0] x;
        logic [VW-1:0] y;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[4];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_yv = -1;
    int   n_yv = 0;

    logic [VW-1:0] w_id [S];
    logic [VW-1:0] w_a  [S];
    logic [VW-1:0] w_b  [S];
    logic [VW-1:0] x_r  [S];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and score any result pulse there
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (y_valid) begin
            last_yv = cyc;
            n_yv++;
            if (sb.size() == 0) begin
                chk("unexpected_y_valid", y_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("y_out", y_out, e.y);
                chk("y_latency", 64'(cyc - e.edge_idx), LAT);
            end
        end
    endtask

    task automatic send_vec(input logic [VW-1:0] x, input logic [VW-1:0] y, output int e);
        int g;
        x_valid = 1'b1;
        x_in    = x;
        #1;
        g = 0;
        while (!x_ready && g < 50) begin
            tick();
            #1;
            g++;
        end
        e = -1;
        if (!x_ready) begin
            chk("x_accept", x_ready, 1'b1);
        end else begin
            e = cyc + 1;
            sb.push_back('{y, e});
        end
        tick();
    endtask

    task automatic load_w(input logic [VW-1:0] w [S], input int gap);
        int g;
        for (int k = 0; k < S; k++) begin
            w_valid = 1'b1;
            w_row   = w[k];
            #1;
            g = 0;
            while (!w_ready && g < 50) begin
                tick();
                #1;
                g++;
            end
            chk("w_accept", w_ready, 1'b1);
            tick();
            if (k < S-1) begin
                w_valid = 1'b0;
                repeat (gap) tick();
            end
        end
        w_valid = 1'b0;
        w_row   = '0;
    endtask

    task automatic burst_check(input logic [VW-1:0] w [S], output int start);
        int g;
        g = 0;
        while (!set_w && g < 20) begin
            tick();
            g++;
        end
        chk("burst_start", set_w, 1'b1);
        start = cyc;
        for (int k = 0; k < S; k++) begin
            chk("burst_set_w", set_w, 1'b1);
            chk("burst_row", w_stream, w[k]);
            tick();
        end
        chk("gap_set_w", set_w, 1'b0);
        chk("gap_w_stream", w_stream, '0);
        chk("gap_x_ready", x_ready, 1'b0);
        tick();
        chk("run_x_ready", x_ready, 1'b1);
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 60) begin
            tick();
            g++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int e, e0, bs, yv0;

        tbl[0] = '{pack3(1,0,0), pack3(1,2,0)};
        tbl[1] = '{pack3(0,1,0), pack3(0,1,1)};
        tbl[2] = '{pack3(0,0,1), pack3(2,0,1)};
        tbl[3] = '{pack3(1,1,1), pack3(3,3,2)};
        w_id[0] = pack3(1,0,0); w_id[1] = pack3(0,1,0); w_id[2] = pack3(0,0,1);
        w_a[0]  = pack3(1,2,0); w_a[1]  = pack3(0,1,1); w_a[2]  = pack3(2,0,1);
        w_b[0]  = pack3(1,1,0); w_b[1]  = pack3(0,2,0); w_b[2]  = pack3(3,0,1);
        x_r[0]  = pack3(1,2,0); x_r[1]  = pack3(0,1,3); x_r[2]  = pack3(2,2,2);

        // Reset values
        repeat (3) tick();
        chk("rst_set_w", set_w, 1'b0);
        chk("rst_w_stream", w_stream, '0);
        chk("rst_data_stream", data_stream, '0);
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_y_out", y_out, '0);
        chk("rst_w_ready", w_ready, 1'b0);
        chk("rst_x_ready", x_ready, 1'b0);
        rst = 1'b0;
        tick();

        // No weights loaded: activations must be refused
        x_valid = 1'b1;
        x_in    = pack3(5,6,7);
        repeat (20) begin
            #1;
            chk("noload_x_ready", x_ready, 1'b0);
            chk("noload_set_w", set_w, 1'b0);
            chk("noload_y_valid", y_valid, 1'b0);
            tick();
        end
        x_valid = 1'b0;

        // Identity load with gaps between rows
        load_w(w_id, 2);
        burst_check(w_id, bs);

        // Single vector: skew pattern and one result
        yv0 = n_yv;
        send_vec(pack3(1,2,3), pack3(1,2,3), e);
        x_valid = 1'b0;
        chk("skew_c0", data_stream, '0);
        tick(); chk("skew_c1", data_stream, pack3(1,0,0));
        tick(); chk("skew_c2", data_stream, pack3(0,2,0));
        tick(); chk("skew_c3", data_stream, pack3(0,0,3));
        tick(); chk("skew_c4", data_stream, '0);
        wait_drain();
        chk("single_pulses", 64'(n_yv - yv0), 1);

        // Streaming with table vectors back-to-back
        load_w(w_a, 1);
        burst_check(w_a, bs);
        e0 = -1;
        for (int i = 0; i < 4; i++) begin
            send_vec(tbl[i].x, tbl[i].y, e);
            if (i == 0) e0 = e;
        end
        x_valid = 1'b0;
        chk("b2b_accepts", 64'(e - e0), 3);
        wait_drain();

        // Reload while three vectors are in flight
        for (int i = 0; i < S; i++) send_vec(x_r[i], matvec(w_a, x_r[i]), e);
        x_in    = pack3(9,9,9);
        w_valid = 1'b1;
        w_row   = w_b[0];
        #1;
        chk("reload_x_ready", x_ready, 1'b0);
        x_valid = 1'b0;
        load_w(w_b, 0);
        burst_check(w_b, bs);
        chk("burst_after_last_y", bs > last_yv, 1'b1);
        chk("reload_sb_empty", sb.size(), 0);
        send_vec(pack3(1,1,1), matvec(w_b, pack3(1,1,1)), e);
        x_valid = 1'b0;
        wait_drain();

        // Reset in burst cycle 1
        load_w(w_a, 0);
        chk("mid_burst_c0", set_w, 1'b1);
        tick();
        chk("mid_burst_c1", set_w, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("arst_set_w", set_w, 1'b0);
        chk("arst_w_stream", w_stream, '0);
        chk("arst_x_ready", x_ready, 1'b0);
        chk("arst_w_ready", w_ready, 1'b0);
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
        x_valid = 1'b1;
        x_in    = pack3(4,4,4);
        repeat (10) begin
            #1;
            chk("post_rst_x_ready", x_ready, 1'b0);
            chk("post_rst_y_valid", y_valid, 1'b0);
            tick();
        end
        x_valid = 1'b0;

        // Full reload recovers normal operation
        load_w(w_b, 1);
        burst_check(w_b, bs);
        send_vec(pack3(2,1,3), matvec(w_b, pack3(2,1,3)), e);
        x_valid = 1'b0;
        wait_drain();

        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/systolic_driver.md
Name: systolic_driver

Overview:
- Front/back end for the weight-stationary systolic array. Drives its `data_stream`, `w_stream` and `set_w` inputs, and collects its combinational `y_stream` output.
- Buffers a full weight matrix, then bursts it into the array with the exact `set_w` timing the array needs.
- Skews input vectors so row r enters r cycles late, and deskews the column outputs into one aligned result vector.
- Accepts one activation vector per cycle through a valid/ready handshake.

Parameters:
- data_size, 16, width of one element.
- size, 3, array dimension (rows = columns = size); must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- w_valid  in  1  a weight row is offered on w_row.
- w_ready  out  1  w_row is accepted on an edge where w_valid && w_ready.
- w_row  in  data_size*size  weight row k; element c is in MSB-first slot c and is destined for column c.
- x_valid  in  1  an activation vector is offered on x_in.
- x_ready  out  1  x_in is accepted on an edge where x_valid && x_ready.
- x_in  in  data_size*size  activation vector; element r is in MSB-first slot r.
- y_valid  out  1  y_out holds a complete result vector (one-cycle pulse per vector).
- y_out  out  data_size*size  result; element c is in MSB-first slot c.
- data_stream  out  data_size*size  to the array; skewed activations.
- w_stream  out  data_size*size  to the array; weight row being loaded.
- set_w  out  1  to the array; weight-load strobe.
- y_stream  in  data_size*size  from the array; per-column results.

Behaviour:
- Reset (async, any time): state=RUN, w_loaded=0, set_w=0, w_stream=0, data_stream=0, all skew/deskew/valid pipes cleared, y_valid=0, y_out=0, w_ready=0, x_ready=0. In-flight vectors are discarded, never emitted.
- The array itself has no reset. After rst, no activation is accepted until a full weight load completes (w_loaded=1).
- States: RUN, DRAIN, W_COLLECT, W_BURST, W_GAP.
- RUN:
  - x_ready = w_loaded && !w_valid.
  - w_valid=1 moves to DRAIN next edge. Weight requests have priority and block new activations that same cycle.
- DRAIN:
  - x_ready=0, w_ready=0.
  - Waits until the valid pipe is empty (no vector in flight), then moves to W_COLLECT.
- W_COLLECT:
  - w_ready=1.
  - Rows are stored into a size×size shadow buffer in arrival order, counted 0..size-1. Gaps in w_valid are allowed.
  - After accepting row size-1, moves to W_BURST.
- W_BURST:
  - Exactly size consecutive cycles with set_w=1; w_stream = shadow row k in burst cycle k.
  - The array therefore writes w_reg[c][k] = W[k][c].
  - Then moves to W_GAP.
- W_GAP:
  - One cycle with set_w=0, so the array's internal row counter returns to 0.
  - Sets w_loaded=1 and returns to RUN.
- set_w is 0 in every state except W_BURST. w_stream is 0 outside W_BURST.
- Skew:
  - For a vector accepted on edge E, data_stream slot r carries x[r] during the cycle starting at edge E+r+1.
  - Lane r is an (r+1)-deep register chain.
  - Bubble cycles inject 0 into each chain.
- Result timing: the array presents column c of that vector on y_stream during the cycle after edge E+size+c+1.
- Deskew:
  - Column c is captured at the end of that cycle, then delayed size-1-c further registers.
  - All columns align in y_out.
  - y_valid=1 and y_out are registered during the cycle starting at edge E+2*size+2. Latency from the accept edge is 2*size+2 edges; for size=3 that is 8.
- Arithmetic: result y[c] = Σ_r W[r][c]·x[r] is computed by the array. This block only moves data: no width change, no arithmetic.
- Throughput: 1 vector/cycle sustained in RUN. Back-to-back vectors never mix, because each (column, stage) slot is time-disjoint.
- Valid pipe: a (2*size+2)-deep shift register of accept flags. y_valid is its tail. "Drained" means all bits are 0.
- No output backpressure: a y_valid pulse must be consumed in its cycle.
- A weight reload while vectors are in flight always completes those vectors with the old weights before W_BURST starts.

Test Plan:
- Reset / no weights: rst pulse, then x_valid=1 for 20 cycles → x_ready=0 throughout; set_w=0; y_valid never asserts.
- Weight load with gaps: rows presented with idle cycles between them → set_w high exactly 3 consecutive cycles carrying rows 0, 1, 2 in order, followed by ≥1 low cycle; x_ready rises the cycle after W_GAP.
- Single vector, size=3, W=identity, x=(1,2,3) (array number encoding) → data_stream slots show 1, 2, 3 staggered on successive cycles; y_valid pulses once, 8 edges after accept; y_out=(1,2,3).
- Streaming: W rows (1,2,0), (0,1,1), (2,0,1); vectors (1,0,0), (0,1,0), (0,0,1), (1,1,1) accepted back-to-back → four consecutive y_valid pulses with y_out = (1,2,0), (0,1,1), (2,0,1), (3,3,2).
- Reload mid-stream: w_valid asserted while 3 vectors are in flight → x_ready drops the same cycle; 3 results emerge with the old W; set_w burst starts only after the last y_valid; the next vector uses the new W.
- Reset mid-operation: rst asserted during W_BURST cycle 1 → set_w=0 immediately (asynchronous); state=RUN, w_loaded=0; no y_valid until the next full load.
